// File: rtl/seq_chunk_subtractor_if.sv
// Operand/result bundle for seq_chunk_subtractor.
// Valid/ready rule on both sides: a transfer happens on a rising clk edge where
// valid and ready are both high; the producer holds its payload stable and keeps
// valid high until that edge, and valid never waits on ready.
interface seq_chunk_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] DIFF;
  logic             borrow;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, DIFF, borrow, zero, ovf
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, DIFF, borrow, zero, ovf
  );
endinterface

// File: rtl/seq_chunk_subtractor.sv
// Multi-cycle A - B (A + ~B + 1), CHUNK bits per clock, carry registered between chunks.
// Optional signed overflow flag: define SEQ_CHUNK_SUBTRACTOR_SIGNED_OVF_EN.
module seq_chunk_subtractor #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_chunk_subtractor_if.slave bus,
  output logic [1:0]           state_dbg
);
  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_chunk_subtractor: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] nb_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] diff_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             borrow_q;
  logic             zero_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] nb_chunk;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] shadow_next;
  logic             last_chunk;

  always_comb begin
    a_chunk     = a_q[idx_q*CHUNK +: CHUNK];
    nb_chunk    = nb_q[idx_q*CHUNK +: CHUNK];
    sum         = {1'b0, a_chunk} + {1'b0, nb_chunk} + {{CHUNK{1'b0}}, carry_q};
    shadow_next = shadow_q;
    shadow_next[idx_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    last_chunk  = (idx_q == IDX_W'(NUM_CHUNKS - 1));
  end

`ifdef SEQ_CHUNK_SUBTRACTOR_SIGNED_OVF_EN
  // Carry into the chunk MSB recovered from its sum bit: s = a ^ b ^ cin.
  logic cin_msb;
  logic ovf_q;

  always_comb begin
    cin_msb = a_chunk[CHUNK-1] ^ nb_chunk[CHUNK-1] ^ sum[CHUNK-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_BUSY && last_chunk) begin
      ovf_q <= cin_msb ^ sum[CHUNK];
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      nb_q     <= '0;
      shadow_q <= '0;
      diff_q   <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q      <= bus.A;
            nb_q     <= ~bus.B;
            carry_q  <= 1'b1;
            idx_q    <= '0;
            shadow_q <= '0;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Result registers move only here, so the visible outputs stay frozen through BUSY.
          shadow_q <= shadow_next;
          carry_q  <= sum[CHUNK];
          if (last_chunk) begin
            idx_q    <= '0;
            diff_q   <= shadow_next;
            borrow_q <= ~sum[CHUNK];
            zero_q   <= (shadow_next == '0);
            state_q  <= S_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.DIFF      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.zero      = zero_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_seq_chunk_subtractor.sv
// Bench for seq_chunk_subtractor (WIDTH=8, CHUNK=2): directed scenarios plus random ops
// checked against an arithmetic reference model.
module tb_seq_chunk_subtractor;
  localparam int WIDTH      = 8;
  localparam int CHUNK      = 2;
  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int W          = WIDTH + 3;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  seq_chunk_subtractor_if #(.WIDTH(WIDTH)) bus ();

  seq_chunk_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  logic [W-1:0] exp_q[$];

  // {ovf, zero, borrow, diff} from plain integer arithmetic
  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int ua, ub, sa, sb, d, sd;
    logic [WIDTH-1:0] diff;
    logic ov;
    ua = int'(a);
    ub = int'(b);
    d  = (ua - ub + 256) % 256;
    diff = d[WIDTH-1:0];
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    sd = sa - sb;
`ifdef SEQ_CHUNK_SUBTRACTOR_SIGNED_OVF_EN
    ov = (sd > 127) || (sd < -128);
`else
    ov = 1'b0;
`endif
    return {ov, (d == 0), (ua < ub), diff};
  endfunction

  // driver: one full operation with optional backpressure; junk=1 keeps in_valid high with A=0xFF
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int stall, input logic junk, input string name);
    int guard;
    int lat;
    logic [W-1:0] exp;
    logic [W-1:0] got;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready_wait: got %b required 1", name, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.in_valid = junk;
    bus.A = junk ? 8'hFF : WIDTH'($urandom_range(0, 255));
    bus.B = WIDTH'($urandom_range(0, 255));
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 20);
    n_checks++;
    if (lat != NUM_CHUNKS || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles (out_valid=%b) required %0d", name, lat, bus.out_valid, NUM_CHUNKS);
    end
    exp = exp_q.pop_front();
    got = {bus.ovf, bus.zero, bus.borrow, bus.DIFF};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s result: got ovf/zero/borrow/diff=%b/%b/%b/%h required %b/%b/%b/%h",
               name, got[W-1], got[W-2], got[W-3], got[WIDTH-1:0], exp[W-1], exp[W-2], exp[W-3], exp[WIDTH-1:0]);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      got = {bus.ovf, bus.zero, bus.borrow, bus.DIFF};
      n_checks++;
      if (got !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold[%0d]: got diff=%h out_valid=%b in_ready=%b required diff=%h out_valid=1 in_ready=0",
                 name, i, got[WIDTH-1:0], bus.out_valid, bus.in_ready, exp[WIDTH-1:0]);
      end
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    got = {bus.ovf, bus.zero, bus.borrow, bus.DIFF};
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || got !== exp) begin
      n_fail++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b diff=%h required 0/1/%h",
               name, bus.out_valid, bus.in_ready, got[WIDTH-1:0], exp[WIDTH-1:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.DIFF, bus.borrow, bus.zero, bus.ovf} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_values: got in_ready=%b out_valid=%b diff=%h b/z/o=%b%b%b required 1 0 00 000",
               bus.in_ready, bus.out_valid, bus.DIFF, bus.borrow, bus.zero, bus.ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    run_op(8'h35, 8'h12, 0, 1'b0, "sub_35_12");
    run_op(8'h12, 8'h35, 1, 1'b0, "sub_12_35");
    run_op(8'h40, 8'h40, 0, 1'b0, "sub_40_40");
    run_op(8'h80, 8'h01, 2, 1'b0, "sub_80_01");
    run_op(8'h05, 8'h03, 0, 1'b0, "sub_05_03");
    run_op(8'h00, 8'hFF, 0, 1'b0, "sub_00_ff");
    run_op(8'hFF, 8'h00, 0, 1'b0, "sub_ff_00");
    run_op(8'h7F, 8'hFF, 0, 1'b0, "sub_7f_ff");
    run_op(8'h00, 8'h00, 0, 1'b0, "sub_00_00");
  endtask

  task automatic test_backpressure();
    run_op(8'h35, 8'h12, 3, 1'b1, "backpressure");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = 8'hC3;
    bus.B = 8'h11;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.DIFF !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: got in_ready=%b out_valid=%b diff=%h required 1 0 00",
               bus.in_ready, bus.out_valid, bus.DIFF);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h09, 8'h03, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/seq_chunk_subtractor.md
Name: seq_chunk_subtractor

Overview:
- Multi-cycle two's-complement subtractor that computes DIFF = A - B over WIDTH bits.
- Processes CHUNK bits per clock and registers the carry between chunks. Result is A + ~B + 1, formed from full-adder chunks.
- Sits in the vector ALU datapath as the area-optimised counterpart to the single-cycle adder.
- Valid/ready handshakes on both input and output. One operation in flight at a time.

Parameters:
- WIDTH, 8, operand and result width in bits.
- CHUNK, 2, bits processed per cycle. WIDTH % CHUNK must equal 0; elaboration error otherwise.
- NUM_CHUNKS (localparam), WIDTH/CHUNK, number of compute cycles.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- DIFF  output  WIDTH  A - B, modulo 2^WIDTH.
- borrow  output  1  1 when unsigned A < B, i.e. the final carry inverted.
- zero  output  1  1 when DIFF == 0.
- ovf  output  1  signed overflow (see Optional Feature).

Behaviour:
- Only the clock and asynchronous active-high reset govern timing. Reset forces:
  - state = IDLE, in_ready = 1, out_valid = 0
  - DIFF = 0, borrow = 0, zero = 0, ovf = 0
  - carry register = 0, chunk index = 0
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch A and ~B, set carry = 1, set index = 0, go to BUSY.
- BUSY:
  - in_ready = 0; in_valid is ignored.
  - Each cycle: DIFF[idx*CHUNK +: CHUNK] <= A_chunk + ~B_chunk + carry. Carry <= chunk carry-out. idx++.
  - The carry into the MSB of the last chunk (prev carry) is also captured.
  - When idx == NUM_CHUNKS-1 on that cycle's edge: go to DONE, assert out_valid, set borrow = ~carry_out, set zero = (full DIFF == 0).
- Latency: the accept edge is E0. out_valid is high after edge E_NUM_CHUNKS (4 cycles with the defaults).
- DONE:
  - out_valid = 1.
  - DIFF, borrow, zero and ovf are held stable until out_ready = 1.
  - On out_valid && out_ready: go to IDLE, out_valid = 0 on the next cycle, in_ready = 1 on the next cycle.
  - No same-cycle accept of a new operation: throughput is one op per NUM_CHUNKS+2 cycles minimum.
- Outputs change only on entering DONE or on reset. DIFF is not updated in the output register during BUSY: chunks go to an internal shadow, and the shadow is copied on DONE entry.
- Reset asserted mid-BUSY or mid-DONE: immediately returns to IDLE with all reset values. The partial result is discarded.
- Degenerate case CHUNK == WIDTH: NUM_CHUNKS = 1, BUSY lasts exactly one cycle.
- Arithmetic wraps modulo 2^WIDTH. Operands are treated as raw bit vectors.

Optional Feature:
- Macro: SEQ_CHUNK_SUBTRACTOR_SIGNED_OVF_EN.
- Defined: ovf = carry_into_MSB XOR carry_out_of_MSB, captured on DONE entry. It is valid with out_valid and reset to 0.
- Not defined: ovf is tied to 0 and the prev-carry capture logic is omitted.

Test Plan:
All scenarios use WIDTH=8, CHUNK=2.
1. A=0x35, B=0x12, accept at E0 -> out_valid after E4; DIFF=0x23, borrow=0, zero=0.
2. A=0x12, B=0x35 -> DIFF=0xDD, borrow=1, zero=0.
3. A=0x40, B=0x40 -> DIFF=0x00, zero=1, borrow=0.
4. Backpressure: scenario 1 with out_ready low for 3 cycles after out_valid, and in_valid held high with A=0xFF -> DIFF stays 0x23 and in_ready stays 0; after the out_ready pulse, out_valid=0 and in_ready=1 the next cycle.
5. Reset mid-operation: assert rst 2 cycles after accept -> next sample shows in_ready=1, out_valid=0, DIFF=0; a new op (0x09 - 0x03) then yields DIFF=0x06.
6. A=0x80, B=0x01 -> DIFF=0x7F, borrow=0; ovf=1 with SEQ_CHUNK_SUBTRACTOR_SIGNED_OVF_EN, ovf=0 without. Also A=0x05, B=0x03 -> ovf=0 in both builds.
